lcd_ctrl: RTL and testbench

Image display controller for a small LCD.
- Loads a 12-column x 9-row, 8-bit grayscale image (108 pixels, raster order) into internal storage.
- After every accepted command, streams a 4x4 view (16 pixels) to the display.
- Supports a down-sampled "fit" view and a 1:1 "zoom-in" window that can be panned.

---
 rtl/lcd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_lcd_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// Display controller for a 12x9 8-bit grayscale image: loads the frame, then
// streams a 4x4 view (down-sampled fit or pannable 1:1 zoom) after every command.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for a command, busy=0
// S_LOAD   | capturing 108 pixels from datain in raster order
// S_OUTPUT | streaming the 16 pixels of the current view
// S_DONE   | one cycle after the last pixel: drop output_valid and busy
module lcd_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] datain,
    input  logic [2:0] cmd,
    input  logic       cmd_valid,
    output logic [7:0] dataout,
    output logic       output_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_OUTPUT,
        S_DONE
    } state_t;

    typedef enum logic {
        M_FIT,
        M_ZOOM
    } mode_t;

    localparam logic [2:0] CMD_LOAD     = 3'd0;
    localparam logic [2:0] CMD_ZOOM_IN  = 3'd1;
    localparam logic [2:0] CMD_ZOOM_FIT = 3'd2;
    localparam logic [2:0] CMD_RIGHT    = 3'd3;
    localparam logic [2:0] CMD_LEFT     = 3'd4;
    localparam logic [2:0] CMD_UP       = 3'd5;
    localparam logic [2:0] CMD_DOWN     = 3'd6;

    localparam logic [3:0] X_HOME = 4'd6;
    localparam logic [3:0] Y_HOME = 4'd4;
    localparam logic [3:0] X_MIN  = 4'd2;
    localparam logic [3:0] X_MAX  = 4'd10;
    localparam logic [3:0] Y_MIN  = 4'd2;
    localparam logic [3:0] Y_MAX  = 4'd7;

    localparam logic [6:0] LAST_PIXEL = 7'd107;
    localparam logic [3:0] LAST_VIEW  = 4'd15;

    logic [7:0] img [0:107];

    state_t     state;
    mode_t      mode;
    logic [3:0] org_x;
    logic [3:0] org_y;
    logic [6:0] ld_left;
    logic [3:0] px_left;

    logic [3:0] px_idx;
    logic [3:0] rd_row;
    logic [3:0] rd_col;
    logic [6:0] rd_addr;
    logic [6:0] wr_addr;

    // Both timers count down; the running index is recovered from the remainder.
    always_comb begin
        px_idx  = LAST_VIEW - px_left;
        wr_addr = LAST_PIXEL - ld_left;
        rd_row  = 4'd0;
        rd_col  = 4'd0;
        if (mode == M_FIT) begin
            rd_row = {1'b0, px_idx[3:2], 1'b1};
            rd_col = ({2'b00, px_idx[1:0]} << 1) + {2'b00, px_idx[1:0]} + 4'd1;
        end else begin
            rd_row = org_y - 4'd2 + {2'b00, px_idx[3:2]};
            rd_col = org_x - 4'd2 + {2'b00, px_idx[1:0]};
        end
        rd_addr = ({3'b000, rd_row} << 3) + ({3'b000, rd_row} << 2) + {3'b000, rd_col};
    end

    // Image contents are don't-care after reset, so storage has no reset.
    always_ff @(posedge clk) begin
        if (state == S_LOAD) begin
            img[wr_addr] <= datain;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            mode         <= M_FIT;
            org_x        <= X_HOME;
            org_y        <= Y_HOME;
            ld_left      <= 7'd0;
            px_left      <= 4'd0;
            dataout      <= 8'd0;
            output_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && !busy) begin
                        busy    <= 1'b1;
                        px_left <= LAST_VIEW;
                        state   <= S_OUTPUT;
                        case (cmd)
                            CMD_LOAD: begin
                                ld_left <= LAST_PIXEL;
                                state   <= S_LOAD;
                            end
                            CMD_ZOOM_IN: begin
                                if (mode == M_FIT) begin
                                    mode  <= M_ZOOM;
                                    org_x <= X_HOME;
                                    org_y <= Y_HOME;
                                end
                            end
                            CMD_ZOOM_FIT: begin
                                mode  <= M_FIT;
                                org_x <= X_HOME;
                                org_y <= Y_HOME;
                            end
                            CMD_RIGHT: begin
                                if (mode == M_ZOOM && org_x < X_MAX) org_x <= org_x + 4'd1;
                            end
                            CMD_LEFT: begin
                                if (mode == M_ZOOM && org_x > X_MIN) org_x <= org_x - 4'd1;
                            end
                            CMD_UP: begin
                                if (mode == M_ZOOM && org_y > Y_MIN) org_y <= org_y - 4'd1;
                            end
                            CMD_DOWN: begin
                                if (mode == M_ZOOM && org_y < Y_MAX) org_y <= org_y + 4'd1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    if (ld_left == 7'd0) begin
                        mode  <= M_FIT;
                        org_x <= X_HOME;
                        org_y <= Y_HOME;
                        state <= S_OUTPUT;
                    end else begin
                        ld_left <= ld_left - 7'd1;
                    end
                end
                S_OUTPUT: begin
                    dataout      <= img[rd_addr];
                    output_valid <= 1'b1;
                    if (px_left == 4'd0) begin
                        state <= S_DONE;
                    end else begin
                        px_left <= px_left - 4'd1;
                    end
                end
                S_DONE: begin
                    output_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl: loads pixel[a]=a and checks every streamed view
// against hand-derived address lists.
module tb_lcd_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] datain = 8'd0;
    logic [2:0] cmd = 3'd0;
    logic       cmd_valid = 1'b0;
    logic [7:0] dataout;
    logic       output_valid;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_blk[16];
    int got_blk[16];
    int fit_list[16] = '{13, 16, 19, 22, 37, 40, 43, 46, 61, 64, 67, 70, 85, 88, 91, 94};

    lcd_ctrl dut (
        .clk(clk),
        .reset(reset),
        .datain(datain),
        .cmd(cmd),
        .cmd_valid(cmd_valid),
        .dataout(dataout),
        .output_valid(output_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_fit();
        for (int i = 0; i < 16; i++) exp_blk[i] = fit_list[i];
    endtask

    task automatic set_zoom(input int x, input int y);
        for (int i = 0; i < 16; i++) exp_blk[i] = (y - 2 + i / 4) * 12 + (x - 2 + i % 4);
    endtask

    task automatic issue(input logic [2:0] c);
        @(negedge clk);
        cmd       = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("accept_busy", busy, 1);
    endtask

    task automatic do_load();
        issue(3'd0);
        for (int k = 0; k < 108; k++) begin
            datain = k[7:0];
            if (k == 60) check("load_busy", busy, 1);
            if (k == 60) check("load_no_valid", output_valid, 0);
            @(negedge clk);
        end
        datain = 8'hFF;
    endtask

    task automatic collect(input string tag, input bit inject);
        int t = 0;
        while (output_valid !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_start"}, output_valid, 1);
        if (output_valid === 1'b1) begin
            for (int i = 0; i < 16; i++) begin
                check($sformatf("%s_valid%0d", tag, i), output_valid, 1);
                check($sformatf("%s_px%0d", tag, i), dataout, exp_blk[i]);
                got_blk[i] = int'(dataout);
                if (inject && i == 4) begin
                    cmd       = 3'd1;
                    cmd_valid = 1'b1;
                end
                if (inject && i == 5) cmd_valid = 1'b0;
                @(negedge clk);
            end
            check({tag, "_end_valid"}, output_valid, 0);
            check({tag, "_end_busy"}, busy, 0);
        end
    endtask

    task automatic idle_check(input string tag, input int n, input int last);
        for (int i = 0; i < n; i++) begin
            check({tag, "_idle_valid"}, output_valid, 0);
            check({tag, "_idle_hold"}, dataout, last);
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", output_valid, 0);
        check("rst_dataout", dataout, 0);
        reset = 1'b0;

        do_load();
        set_fit();
        collect("load_fit", 1'b0);
        idle_check("after_load", 3, 94);

        issue(3'd1);
        set_zoom(6, 4);
        collect("zoom_in", 1'b0);
        check("zoom_first", got_blk[0], 'h1C);

        for (int s = 1; s <= 5; s++) begin
            issue(3'd3);
            set_zoom((6 + s > 10) ? 10 : 6 + s, 4);
            collect($sformatf("right%0d", s), 1'b0);
        end
        check("right_clamp_first", got_blk[0], 'h20);
        check("right_clamp_last", got_blk[15], 'h47);

        issue(3'd2);
        set_fit();
        collect("fit_a", 1'b0);
        issue(3'd1);
        set_zoom(6, 4);
        collect("zoom_b", 1'b0);
        for (int s = 1; s <= 3; s++) begin
            issue(3'd5);
            set_zoom(6, (4 - s < 2) ? 2 : 4 - s);
            collect($sformatf("up%0d", s), 1'b0);
        end
        check("up_clamp_first", got_blk[0], 'h04);
        check("up_clamp_last", got_blk[15], 'h2B);

        issue(3'd2);
        set_fit();
        collect("fit_b", 1'b0);
        issue(3'd1);
        set_zoom(6, 4);
        collect("zoom_c", 1'b0);
        for (int s = 1; s <= 5; s++) begin
            issue(3'd4);
            set_zoom((6 - s < 2) ? 2 : 6 - s, 4);
            collect($sformatf("left%0d", s), 1'b0);
        end
        for (int s = 1; s <= 4; s++) begin
            issue(3'd6);
            set_zoom(2, (4 + s > 7) ? 7 : 4 + s);
            collect($sformatf("down%0d", s), 1'b0);
        end
        check("corner_first", got_blk[0], 'h3C);
        check("corner_last", got_blk[15], 'h63);

        issue(3'd2);
        set_fit();
        collect("fit_c", 1'b0);

        // Shift in FIT mode with a zoom-in pulsed while busy; the pulse must vanish.
        issue(3'd3);
        set_fit();
        collect("fit_shift_busy", 1'b1);
        idle_check("ignored", 8, 94);
        issue(3'd7);
        set_fit();
        collect("reserved_fit", 1'b0);

        issue(3'd1);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_valid", output_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_dataout", dataout, 0);
        reset = 1'b0;
        idle_check("post_rst", 3, 0);

        do_load();
        set_fit();
        collect("reload_fit", 1'b0);
        issue(3'd1);
        set_zoom(6, 4);
        collect("reload_zoom", 1'b0);
        issue(3'd7);
        collect("reserved_zoom", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
